// File: rtl/types_pkg.sv
// Shared types for the reservation-station scheduler: the rs_data entry format,
// tag/age typedefs and the writeback broadcast bus.
package types_pkg;

  localparam int unsigned RS_DEPTH  = 8;
  localparam int unsigned RS_PREG_W = 7;

  typedef logic [2:0]           rs_age_t;
  typedef logic [RS_PREG_W-1:0] preg_t;

  // 72-bit entry; valid and age are owned by the scheduler, the rest by dispatch.
  typedef struct packed {
    logic        valid;
    rs_age_t     age;
    preg_t       pr1;
    logic        pr1_ready;
    preg_t       pr2;
    logic        pr2_ready;
    preg_t       prd;
    logic [6:0]  opcode;
    logic [2:0]  fu;
    logic [2:0]  rob_idx;
    logic [31:0] imm;
  } rs_data;

  typedef struct packed {
    logic  valid;
    preg_t preg;
  } wb_bus_t;

endpackage

// File: rtl/rs_age_picker.sv
// Combinational oldest-first picker: grants the eligible entry with the smallest age.
module rs_age_picker
  import types_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH,
  parameter int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] elig_i,
  input  rs_age_t          age_i [DEPTH],
  output logic [DEPTH-1:0] grant_o,
  output logic [IdxW-1:0]  sel_idx_o,
  output logic             any_valid_o
);

  always_comb begin
    rs_age_t best;
    best        = '1;
    any_valid_o = 1'b0;
    sel_idx_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig_i[i] && (!any_valid_o || (age_i[i] < best))) begin
        any_valid_o = 1'b1;
        best        = age_i[i];
        sel_idx_o   = IdxW'(i);
      end
    end
    grant_o = '0;
    if (any_valid_o) grant_o[sel_idx_o] = 1'b1;
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Age-ordered reservation station: buffers dispatched entries, snoops writeback
// tags for wakeup and issues the oldest fully-ready entry to one FU port.
module rs_issue_scheduler
  import types_pkg::*;
#(
  parameter int unsigned DEPTH  = RS_DEPTH,
  parameter int unsigned NUM_WB = 2,
  parameter int unsigned PREG_W = RS_PREG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  rs_data                   disp_data,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PREG_W-1:0] wb_preg,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output rs_data                   issue_data,
  output logic [3:0]               occupancy
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_data           entry_q [DEPTH];
  rs_data           entry_d [DEPTH];
  logic [3:0]       occ_q, occ_d;
  wb_bus_t          wb [NUM_WB];
  logic [DEPTH-1:0] elig;
  rs_age_t          ages [DEPTH];
  logic [DEPTH-1:0] grant;
  logic [IdxW-1:0]  sel_idx;
  logic [IdxW-1:0]  free_idx;
  logic             any_elig;
  logic             issue_fire, disp_fire;
  rs_age_t          sel_age;
  rs_data           new_entry;

  always_comb begin
    for (int k = 0; k < NUM_WB; k++) begin
      wb[k].valid = wb_valid[k];
      wb[k].preg  = wb_preg[k*PREG_W +: PREG_W];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = entry_q[i].valid & entry_q[i].pr1_ready & entry_q[i].pr2_ready;
      ages[i] = entry_q[i].age;
    end
  end

  rs_age_picker #(
    .DEPTH(DEPTH),
    .IdxW (IdxW)
  ) u_picker (
    .elig_i     (elig),
    .age_i      (ages),
    .grant_o    (grant),
    .sel_idx_o  (sel_idx),
    .any_valid_o(any_elig)
  );

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entry_q[i].valid) free_idx = IdxW'(i);
    end
  end

  assign disp_ready  = (occ_q < 4'(DEPTH));
  assign issue_valid = any_elig;
  assign issue_data  = any_elig ? entry_q[sel_idx] : '0;
  assign occupancy   = occ_q;
  assign issue_fire  = any_elig & issue_ready & ~flush;
  assign disp_fire   = disp_valid & disp_ready & ~flush;

  always_comb begin
    sel_age         = entry_q[sel_idx].age;
    new_entry       = disp_data;
    new_entry.valid = 1'b1;
    new_entry.age   = occ_q[2:0] - {2'b00, issue_fire};
    // Same-cycle broadcasts must not be lost for the entry being written.
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb[k].valid && (wb[k].preg == disp_data.pr1)) new_entry.pr1_ready = 1'b1;
      if (wb[k].valid && (wb[k].preg == disp_data.pr2)) new_entry.pr2_ready = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid) begin
        for (int k = 0; k < NUM_WB; k++) begin
          if (wb[k].valid && (wb[k].preg == entry_q[i].pr1)) entry_d[i].pr1_ready = 1'b1;
          if (wb[k].valid && (wb[k].preg == entry_q[i].pr2)) entry_d[i].pr2_ready = 1'b1;
        end
        if (issue_fire && grant[i]) begin
          entry_d[i].valid = 1'b0;
        end else if (issue_fire && (entry_q[i].age > sel_age)) begin
          entry_d[i].age = entry_q[i].age - 3'd1;
        end
      end
      if (disp_fire && (free_idx == IdxW'(i))) entry_d[i] = new_entry;
      if (flush) entry_d[i].valid = 1'b0;
    end
    occ_d = flush ? 4'd0 : (occ_q + {3'b000, disp_fire} - {3'b000, issue_fire});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench: an age-ordered queue model predicts per-cycle status and the
// issue stream; a decoupled monitor compares the DUT against those predictions.
module tb_rs_issue_scheduler;
  import types_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, disp_valid, disp_ready, issue_valid, issue_ready;
  rs_data      disp_data, issue_data;
  logic [1:0]  wb_valid;
  logic [13:0] wb_preg;
  logic [3:0]  occupancy;

  rs_issue_scheduler #(
    .DEPTH (8),
    .NUM_WB(2),
    .PREG_W(7)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_data  (disp_data),
    .wb_valid   (wb_valid),
    .wb_preg    (wb_preg),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_data (issue_data),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       exp_valid;
    rs_data     exp_data;
    logic [3:0] exp_occ;
    logic       exp_dr;
  } status_t;

  status_t st_q [$];
  rs_data  iss_q [$];
  rs_data  mq [$];  // model: entries in age order, oldest first
  int      checks = 0;
  int      passed = 0;

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic rs_data wake(input rs_data d, input logic [1:0] wv,
                                  input logic [6:0] p0, input logic [6:0] p1);
    rs_data r = d;
    if ((wv[0] && d.pr1 == p0) || (wv[1] && d.pr1 == p1)) r.pr1_ready = 1'b1;
    if ((wv[0] && d.pr2 == p0) || (wv[1] && d.pr2 == p1)) r.pr2_ready = 1'b1;
    return r;
  endfunction

  function automatic int model_pick();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].pr1_ready && mq[i].pr2_ready) return i;
    end
    return -1;
  endfunction

  function automatic rs_data mk(input int p1, input bit r1, input int p2, input bit r2);
    rs_data d;
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    d = r[71:0];  // valid/age carry junk; the scheduler must ignore them
    d.pr1 = 7'(p1);
    d.pr1_ready = r1;
    d.pr2 = 7'(p2);
    d.pr2_ready = r2;
    return d;
  endfunction

  task automatic drive(input logic dv, input rs_data dd, input logic [1:0] wv,
                       input logic [6:0] p0, input logic [6:0] p1,
                       input logic ir, input logic fl);
    status_t s;
    int      idx;
    logic    fi, fd;
    @(negedge clk);
    idx = model_pick();
    s.exp_valid = (idx >= 0);
    s.exp_data  = '0;
    if (idx >= 0) begin
      s.exp_data       = mq[idx];
      s.exp_data.valid = 1'b1;
      s.exp_data.age   = 3'(idx);
    end
    s.exp_occ = 4'(mq.size());
    s.exp_dr  = (mq.size() < RS_DEPTH);
    st_q.push_back(s);
    fi = (idx >= 0) && ir && !fl;
    fd = dv && (mq.size() < RS_DEPTH) && !fl;
    if (fi) iss_q.push_back(s.exp_data);
    disp_valid  = dv;
    disp_data   = dd;
    wb_valid    = wv;
    wb_preg     = {p1, p0};
    issue_ready = ir;
    flush       = fl;
    if (fl) begin
      mq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i], wv, p0, p1);
      if (fi) mq.delete(idx);
      if (fd) mq.push_back(wake(dd, wv, p0, p1));
    end
  endtask

  task automatic idle(input logic ir);
    drive(1'b0, '0, 2'b00, 7'd0, 7'd0, ir, 1'b0);
  endtask

  // Monitor: compares each cycle's status and every observed issue handshake.
  initial begin
    status_t s;
    forever begin
      @(negedge clk);
      #2;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        check("issue_valid", 72'(issue_valid), 72'(s.exp_valid));
        check("issue_data", issue_data, s.exp_data);
        check("occupancy", 72'(occupancy), 72'(s.exp_occ));
        check("disp_ready", 72'(disp_ready), 72'(s.exp_dr));
        if (issue_valid && issue_ready && !flush) begin
          if (iss_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_issue: got %h expected no issue", issue_data);
          end else begin
            check("issued_entry", issue_data, iss_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_data = '0;
    wb_valid = '0; wb_preg = '0; issue_ready = 1'b0;
    #7;
    check("rst_issue_valid", 72'(issue_valid), 72'd0);
    check("rst_issue_data", issue_data, 72'd0);
    check("rst_occupancy", 72'(occupancy), 72'd0);
    check("rst_disp_ready", 72'(disp_ready), 72'd1);
    #5 reset = 1'b0;

    // Single entry woken by two separate broadcasts
    drive(1'b1, mk(5, 0, 6, 0), 2'b00, 7'd0, 7'd0, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b0, '0, 2'b01, 7'd5, 7'd0, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b0, '0, 2'b10, 7'd0, 7'd6, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Age ordering A, B, C with pulsed issue_ready
    for (int i = 0; i < 3; i++) drive(1'b1, mk(10 + i, 1, 20 + i, 1), 2'b00, 7'd0, 7'd0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      idle(1'b0);
    end

    // Fill, back-pressure, then simultaneous dispatch and issue at occupancy 5
    for (int i = 0; i < 10; i++) drive(1'b1, mk(i, 1, i, 1), 2'b00, 7'd0, 7'd0, 1'b0, 1'b0);
    drive(1'b1, mk(1, 1, 1, 1), 2'b00, 7'd0, 7'd0, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    drive(1'b1, mk(40, 1, 41, 1), 2'b00, 7'd0, 7'd0, 1'b1, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Same-cycle wakeup bypass
    drive(1'b1, mk(9, 0, 3, 1), 2'b01, 7'd9, 7'd0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Flush beats dispatch and issue
    for (int i = 0; i < 4; i++) drive(1'b1, mk(i, 1, i, 1), 2'b00, 7'd0, 7'd0, 1'b0, 1'b0);
    drive(1'b1, mk(2, 1, 2, 1), 2'b00, 7'd0, 7'd0, 1'b1, 1'b1);
    idle(1'b0);

    // Asynchronous reset between edges with 3 entries held
    for (int i = 0; i < 3; i++) drive(1'b1, mk(60, 0, 61, 1), 2'b00, 7'd0, 7'd0, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    disp_valid = 1'b0; wb_valid = '0; issue_ready = 1'b0; flush = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("async_issue_valid", 72'(issue_valid), 72'd0);
    check("async_occupancy", 72'(occupancy), 72'd0);
    mq.delete();
    #1 reset = 1'b0;

    // Randomized traffic with a small tag space so wakeups hit often
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 60,
            mk($urandom_range(0, 15), 1'($urandom), $urandom_range(0, 15), 1'($urandom)),
            2'($urandom), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
            1'($urandom), $urandom_range(0, 99) < 2);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    repeat (2) @(negedge clk);
    #3;
    check("issue_drain", 72'(iss_q.size()), 72'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
